// File: rtl/he_pkg.sv
// Shared definitions for the homomorphic-encryption coefficient datapath blocks.
package he_pkg;
  localparam int COEFF_W_DEF = 30;
  localparam int N_DEF       = 1024;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;
endpackage

// File: rtl/mod_addsub_lane.sv
// One coefficient lane of c = a +/- b mod q: stage 1 forms the raw value and a
// correction flag, stage 2 applies a single +/- q correction.
module mod_addsub_lane
  import he_pkg::*;
#(
  parameter int COEFF_W = COEFF_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               op,
  input  logic [COEFF_W-1:0] a,
  input  logic [COEFF_W-1:0] b,
  input  logic [COEFF_W-1:0] q,
  output logic [COEFF_W-1:0] result
);
  logic [COEFF_W:0]   sum_next;
  logic [COEFF_W:0]   raw_next;
  logic               corr_next;
  logic [COEFF_W:0]   raw_reg;
  logic               corr_reg;
  logic               op_reg;
  logic [COEFF_W-1:0] q_reg;
  logic [COEFF_W:0]   fixed_next;
  logic [COEFF_W-1:0] result_reg;

  always_comb begin
    sum_next = {1'b0, a} + {1'b0, b};
    if (op == OP_SUB) begin
      raw_next  = {1'b0, a - b};
      corr_next = (a < b);
    end else begin
      raw_next  = sum_next;
      corr_next = (sum_next >= {1'b0, q});
    end
  end

  // Only the low COEFF_W bits are kept, so the subtract fix-up wraps mod 2^W.
  always_comb begin
    fixed_next = raw_reg;
    if (corr_reg) begin
      if (op_reg == OP_SUB) fixed_next = raw_reg + {1'b0, q_reg};
      else                  fixed_next = raw_reg - {1'b0, q_reg};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      raw_reg    <= '0;
      corr_reg   <= 1'b0;
      op_reg     <= OP_ADD;
      q_reg      <= '0;
      result_reg <= '0;
    end else if (en) begin
      raw_reg    <= raw_next;
      corr_reg   <= corr_next;
      op_reg     <= op;
      q_reg      <= q;
      result_reg <= fixed_next[COEFF_W-1:0];
    end
  end

  assign result = result_reg;
endmodule

// File: rtl/poly_addsub_stream.sv
// Streaming coefficient-wise modular add/subtract of two polynomials, LANES
// coefficients per beat, 2-stage pipeline with valid/ready on both sides.
module poly_addsub_stream
  import he_pkg::*;
#(
  parameter int COEFF_W = COEFF_W_DEF,
  parameter int N       = N_DEF,
  parameter int LANES   = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     op_in,
  input  logic [COEFF_W-1:0]       q_in,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LANES*COEFF_W-1:0] in_a,
  input  logic [LANES*COEFF_W-1:0] in_b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [LANES*COEFF_W-1:0] out_data,
  output logic                     out_last,
  output logic                     busy
);
  localparam int BEATS = N / LANES;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

  state_t             state_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic               op_reg;
  logic [COEFF_W-1:0] q_reg;
  logic               v1_reg;
  logic               last1_reg;
  logic               out_valid_reg;
  logic               out_last_reg;

  logic               advance;
  logic               xfer;
  logic               beat_op;
  logic [COEFF_W-1:0] beat_q;
  logic               beat_last;

  assign advance  = !out_valid_reg || out_ready;
  assign in_ready = advance;
  assign xfer     = in_valid && advance;

  // The first beat of a polynomial bypasses op_reg/q_reg so it needs no extra cycle.
  always_comb begin
    if (state_reg == S_IDLE) begin
      beat_op   = op_in;
      beat_q    = q_in;
      beat_last = (BEATS == 1);
    end else begin
      beat_op   = op_reg;
      beat_q    = q_reg;
      beat_last = (cnt_reg == LAST_CNT);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
      op_reg    <= OP_ADD;
      q_reg     <= '0;
    end else if (xfer) begin
      case (state_reg)
        S_IDLE: begin
          op_reg <= op_in;
          q_reg  <= q_in;
          if (BEATS > 1) begin
            cnt_reg   <= CNT_W'(1);
            state_reg <= S_RUN;
          end
        end
        S_RUN: begin
          if (cnt_reg == LAST_CNT) begin
            cnt_reg   <= '0;
            state_reg <= S_IDLE;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v1_reg        <= 1'b0;
      last1_reg     <= 1'b0;
      out_valid_reg <= 1'b0;
      out_last_reg  <= 1'b0;
    end else if (advance) begin
      v1_reg        <= in_valid;
      last1_reg     <= in_valid && beat_last;
      out_valid_reg <= v1_reg;
      out_last_reg  <= last1_reg;
    end
  end

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    mod_addsub_lane #(
      .COEFF_W(COEFF_W)
    ) u_lane (
      .clk   (clk),
      .reset (reset),
      .en    (advance),
      .op    (beat_op),
      .a     (in_a[gi*COEFF_W +: COEFF_W]),
      .b     (in_b[gi*COEFF_W +: COEFF_W]),
      .q     (beat_q),
      .result(out_data[gi*COEFF_W +: COEFF_W])
    );
  end

  assign out_valid = out_valid_reg;
  assign out_last  = out_last_reg;
  assign busy      = (state_reg == S_RUN) || v1_reg || out_valid_reg;
endmodule

// File: tb/tb_poly_addsub_stream.sv
// Directed bench for poly_addsub_stream: three instances (N=8/L=1, N=8/L=4, N=2/L=2).
module tb_poly_addsub_stream;
  import he_pkg::*;

  localparam int W = 30;
  localparam logic [W-1:0] Q3 = 30'h3FFFFFDD;  // 2^30 - 35

  logic clk = 1'b0;
  logic reset = 1'b1;

  logic op1, iv1, ir1, ov1, or1, ol1, busy1;
  logic [W-1:0] q1, a1, b1, od1;
  logic op4, iv4, ir4, ov4, or4, ol4, busy4;
  logic [W-1:0] q4;
  logic [4*W-1:0] a4, b4, od4;
  logic op2, iv2, ir2, ov2, or2, ol2, busy2;
  logic [W-1:0] q2;
  logic [2*W-1:0] a2, b2, od2;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  bit rdy_rand = 1'b0;
  int first_xfer = -1;
  int first_out = -1;
  logic [W-1:0] exp_d[$];
  bit exp_l[$];

  logic [W-1:0] exp1 [8] = '{10, 11, 12, 13, 14, 15, 16, 0};
  logic [W-1:0] ta2  [8] = '{3, 5, 16, 0, 16, 0, 10, 4};
  logic [W-1:0] tb2  [8] = '{5, 3, 16, 1, 0, 0, 4, 10};
  logic [W-1:0] te2  [8] = '{15, 2, 0, 16, 16, 0, 6, 11};
  logic [W-1:0] exp5 [8] = '{13, 14, 15, 16, 0, 1, 2, 3};

  poly_addsub_stream #(.COEFF_W(W), .N(8), .LANES(1)) u_dut1 (
    .clk(clk), .reset(reset), .op_in(op1), .q_in(q1), .in_valid(iv1), .in_ready(ir1),
    .in_a(a1), .in_b(b1), .out_valid(ov1), .out_ready(or1), .out_data(od1),
    .out_last(ol1), .busy(busy1));

  poly_addsub_stream #(.COEFF_W(W), .N(8), .LANES(4)) u_dut4 (
    .clk(clk), .reset(reset), .op_in(op4), .q_in(q4), .in_valid(iv4), .in_ready(ir4),
    .in_a(a4), .in_b(b4), .out_valid(ov4), .out_ready(or4), .out_data(od4),
    .out_last(ol4), .busy(busy4));

  poly_addsub_stream #(.COEFF_W(W), .N(2), .LANES(2)) u_dut2 (
    .clk(clk), .reset(reset), .op_in(op2), .q_in(q2), .in_valid(iv2), .in_ready(ir2),
    .in_a(a2), .in_b(b2), .out_valid(ov2), .out_ready(or2), .out_data(od2),
    .out_last(ol2), .busy(busy2));

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Plain modular reference for inputs below q.
  function automatic logic [W-1:0] ref_mod(input logic op, input logic [W-1:0] q,
                                           input logic [W-1:0] a, input logic [W-1:0] b);
    longint unsigned r;
    if (op == OP_ADD) r = (longint'(a) + longint'(b)) % longint'(q);
    else              r = (longint'(a) + longint'(q) - longint'(b)) % longint'(q);
    return W'(r);
  endfunction

  initial begin
    or1 = 1'b1;
    forever begin
      @(posedge clk); #1;
      or1 = rdy_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
  end

  // Output monitor for u_dut1: every presented beat must match the head of the
  // expected queue, including while it is held under back-pressure.
  initial forever begin
    @(negedge clk);
    if (reset) begin
      exp_d.delete();
      exp_l.delete();
    end else if (ov1) begin
      if (first_out < 0 && first_xfer >= 0) first_out = cyc;
      if (exp_d.size() == 0) begin
        check_eq("p1_spurious_valid", ov1, 0);
      end else begin
        check_eq("p1_data", od1, exp_d[0]);
        check_eq("p1_last", ol1, exp_l[0]);
        $display("beat data=%0d last=%0b ready=%0b", od1, ol1, or1);
        if (or1) begin
          void'(exp_d.pop_front());
          void'(exp_l.pop_front());
        end
      end
    end
  end

  task automatic send1(input logic op, input logic [W-1:0] q, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] exp, input bit last,
                       input bit first, input int gap_max);
    int gap;
    bit done;
    gap = (gap_max > 0) ? $urandom_range(0, gap_max) : 0;
    done = 1'b0;
    iv1 = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    iv1 = 1'b1;
    op1 = first ? op : ~op;
    q1  = first ? q : 30'd5;
    a1  = a;
    b1  = b;
    for (int t = 0; t < 1000 && !done; t++) begin
      @(negedge clk);
      if (ir1) begin
        done = 1'b1;
        exp_d.push_back(exp);
        exp_l.push_back(last);
        if (first_xfer < 0) first_xfer = cyc;
      end
      @(posedge clk); #1;
    end
    if (!done) check_eq("p1_in_ready_timeout", ir1, 1);
    iv1 = 1'b0;
  endtask

  task automatic drain1();
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (exp_d.size() == 0 && !busy1) break;
    end
    check_eq("p1_drain_left", exp_d.size(), 0);
    check_eq("p1_drain_busy", busy1, 0);
    @(posedge clk); #1;
  endtask

  task automatic send_poly1(input logic op, input logic [W-1:0] q, input int ma, input int ka,
                            input int mb, input int kb);
    logic [W-1:0] a, b;
    for (int i = 0; i < 8; i++) begin
      a = W'((i * ma + ka) % q);
      b = W'((i * mb + kb) % q);
      send1(op, q, a, b, ref_mod(op, q, a, b), i == 7, i == 0, 2);
    end
  endtask

  initial begin
    op1 = OP_ADD; q1 = 17; iv1 = 0; a1 = 0; b1 = 0;
    op4 = OP_ADD; q4 = Q3; iv4 = 0; a4 = 0; b4 = 0; or4 = 1;
    op2 = OP_ADD; q2 = 17; iv2 = 0; a2 = 0; b2 = 0; or2 = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_out_valid", ov1, 0);
    check_eq("rst_out_last", ol1, 0);
    check_eq("rst_out_data", od1, 0);
    check_eq("rst_busy", busy1, 0);
    check_eq("rst_in_ready", ir1, 1);
    @(posedge clk); #1;
    reset = 1'b0;

    // 1: add, q=17, a=i, b=10
    for (int i = 0; i < 8; i++) send1(OP_ADD, 17, W'(i), 10, exp1[i], i == 7, i == 0, 0);
    drain1();
    check_eq("latency", first_out - first_xfer, 2);

    // 2: subtract with borrow and equal operands
    for (int i = 0; i < 8; i++) send1(OP_SUB, 17, ta2[i], tb2[i], te2[i], i == 7, i == 0, 0);
    drain1();

    // 4: three back-to-back polynomials with gaps and random back-pressure
    rdy_rand = 1'b1;
    send_poly1(OP_ADD, 17, 7, 0, 5, 3);
    send_poly1(OP_SUB, 97, 13, 0, 29, 50);
    send_poly1(OP_ADD, 17, 16, 16, 1, 9);
    rdy_rand = 1'b0;
    drain1();

    // 5: reset in the middle of a polynomial
    for (int i = 0; i < 3; i++) send1(OP_ADD, 17, W'(i), 1, W'(i + 1), 1'b0, i == 0, 0);
    reset = 1'b1;
    iv1 = 1'b1; a1 = 3; b1 = 1;
    @(posedge clk); #1;
    check_eq("rst_mid_out_valid", ov1, 0);
    check_eq("rst_mid_busy", busy1, 0);
    reset = 1'b0;
    iv1 = 1'b0;
    for (int i = 0; i < 8; i++) send1(OP_ADD, 17, W'(i + 9), 4, exp5[i], i == 7, i == 0, 0);
    drain1();

    // 3: four lanes, a=b=q-1 with a large modulus
    op4 = OP_ADD; q4 = Q3;
    a4 = {4{Q3 - 30'd1}}; b4 = {4{Q3 - 30'd1}};
    for (int j = 0; j < 4; j++) begin
      iv4 = (j < 2);
      @(negedge clk);
      if (j == 0) check_eq("l4_in_ready", ir4, 1);
      if (j >= 2) begin
        check_eq("l4_out_valid", ov4, 1);
        check_eq("l4_data", od4, {4{30'h3FFFFFDB}});
        check_eq("l4_last", ol4, (j == 3));
        $display("l4 beat %0d data=0x%0h last=%0b", j - 2, od4, ol4);
      end
      @(posedge clk); #1;
    end

    // 6: one beat per polynomial
    op2 = OP_ADD; q2 = 17; b2 = {30'd5, 30'd2};
    for (int j = 0; j < 6; j++) begin
      iv2 = (j < 3);
      a2 = {30'd16, W'(j)};
      @(negedge clk);
      if (j >= 2 && j < 5) begin
        check_eq("b1_out_valid", ov2, 1);
        check_eq("b1_data", od2, {30'd4, W'(j)});
        check_eq("b1_last", ol2, 1);
        $display("b1 beat %0d data=0x%0h last=%0b", j - 2, od2, ol2);
      end
      if (j == 4) check_eq("b1_busy_hold", busy2, 1);
      if (j == 5) begin
        check_eq("b1_busy_drop", busy2, 0);
        check_eq("b1_valid_drop", ov2, 0);
      end
      @(posedge clk); #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
